multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter: MD_CYCLES, 32, number of cycles the mult unit needs after start (2..63).
REQ-002 SHALL have port: i_clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: i_opcode  input  6  IR[31:26]; i_funct  input  6  IR[5:0]; i_zero  input  1  ALU zero flag.
REQ-005 SHALL have port: i_mem_ready  input  1  memory completes the current read/write this cycle.
REQ-006 SHALL have 1-bit outputs: o_pc_write, o_pc_write_cond, o_iord, o_mem_read, o_mem_write, o_ir_write, o_mem_to_reg, o_reg_dst, o_reg_write, o_alu_src_a.
REQ-007 SHALL have 2-bit outputs: o_alu_src_b, o_alu_op, o_pc_src.
REQ-008 SHALL have outputs: o_md_start 1, o_lo_write 1, o_illegal 1 (one-cycle pulse), o_state 4 (current state code).

Function
REQ-009 SHALL implement FSM states/codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11, MDWAIT 12.
REQ-010 SHALL decode opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000; funct mult 011000.
REQ-011 FETCH SHALL drive mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write=pc_write=i_mem_ready; stay until i_mem_ready=1, then DECODE.
REQ-012 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=00; next: lw/sw->MEMADR, R-type->EXEC, beq->BRANCH, addi->ADDIEXEC, j->JUMP, other->FETCH with o_illegal=1 that cycle.
REQ-013 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00; next MEMRD (lw) or MEMWR (sw).
REQ-014 MEMRD SHALL drive mem_read=1, iord=1, wait for i_mem_ready, then MEMWB; MEMWB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0, then FETCH.
REQ-015 MEMWR SHALL drive mem_write=1, iord=1, hold until i_mem_ready=1, then FETCH.
REQ-016 EXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10; next ALUWB, or MDWAIT when funct=mult and MULTDIV_EN defined; ALUWB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
REQ-017 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write_cond=1, then FETCH (PC update gated by i_zero in datapath).
REQ-018 ADDIEXEC SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB; ADDIWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
REQ-019 JUMP SHALL drive pc_src=10, pc_write=1, then FETCH.
REQ-020 Every output not named for a state SHALL be 0 in that state; mem_read and mem_write SHALL never be 1 together.
REQ-021 MDWAIT: o_md_start=1 only on first MDWAIT cycle; 6-bit counter loads MD_CYCLES-1 on entry, decrements each cycle; at count 0 o_lo_write=1 and next FETCH (MDWAIT lasts exactly MD_CYCLES cycles).
REQ-022 i_mem_ready outside FETCH/MEMRD/MEMWR SHALL be ignored.

Reset
REQ-023 i_rst=1 SHALL immediately force state FETCH, counter 0, and all outputs 0 (including o_mem_read) regardless of clock, including mid-MDWAIT or mid-memory-wait.
REQ-024 First rising edge after i_rst falls SHALL sample FETCH with normal FETCH outputs.

Configuration
REQ-025 Macro MULTDIV_EN defined: mult sequenced via MDWAIT per REQ-021.
REQ-026 MULTDIV_EN undefined: no counter logic; R-type funct=mult SHALL go EXEC->FETCH with o_illegal=1 in EXEC, no reg_write; o_md_start, o_lo_write tied 0; state 12 unreachable.

Structure
REQ-027 Package mc_ctrl_pkg SHALL hold opcode/funct constants, state encodings, alu_op and pc_src encodings.
REQ-028 Counter SHALL be sub-module md_counter (load, decrement, zero flag), instantiated only under MULTDIV_EN.

Verification
REQ-029 lw, i_mem_ready=1 always -> states 0,1,2,3,4,0; reg_write=1 only in MEMWB; 5 cycles.
REQ-030 sw with i_mem_ready low 3 cycles in MEMWR -> mem_write held 4 cycles, then FETCH; no reg_write.
REQ-031 beq -> BRANCH has pc_write_cond=1, pc_src=01; j -> JUMP pc_write=1, pc_src=10; each 3 cycles.
REQ-032 mult, MD_CYCLES=4, MULTDIV_EN -> md_start one cycle, lo_write in 4th MDWAIT cycle, then FETCH; without macro -> o_illegal in EXEC, no lo_write.
REQ-033 opcode 111111 -> o_illegal in DECODE, return FETCH, no writes.
REQ-034 i_rst asserted mid-MDWAIT and mid-MEMRD wait -> outputs 0 same timestep, FETCH after release.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants for the multicycle controller
// Holds the opcode/funct codes, the FSM state encodings and the alu_op and pc_src encodings.
package mc_ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] FN_MULT  = 6'b011000;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMRD    = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWR    = 4'd5,
        ST_EXEC     = 4'd6,
        ST_ALUWB    = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_ADDIEXEC = 4'd9,
        ST_ADDIWB   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_MDWAIT   = 4'd12
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_ALU = 2'b00,
        PC_BR  = 2'b01,
        PC_JMP = 2'b10
    } pc_src_e;
endpackage

// File: rtl/md_counter.sv
// md_counter: 6-bit down counter that times the multiply unit
// Ports: i_clk, i_rst (async, active-high), i_load loads i_load_val, i_dec decrements,
//        o_count is the current value, o_zero flags a count of 0.
module md_counter (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic       i_dec,
    input  logic [5:0] i_load_val,
    output logic [5:0] o_count,
    output logic       o_zero
);
    logic [5:0] cnt_q, cnt_d;

    always_comb cnt_d = i_load ? i_load_val : i_dec ? cnt_q - 6'd1 : cnt_q;

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;

    assign o_count = cnt_q;
    assign o_zero  = cnt_q == '0;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: control FSM for a multicycle MIPS-style datapath
// Ports: i_clk, i_rst (async, active-high), i_opcode/i_funct from IR, i_zero (ALU zero,
//        consumed by the datapath's PC gating), i_mem_ready (memory done this cycle);
//        outputs are the datapath control strobes, o_md_start/o_lo_write for the
//        multiplier, o_illegal (one-cycle pulse) and o_state (current state code).
// Build option: define MULTDIV_EN to sequence mult through the MDWAIT state; without it
//        mult is flagged illegal in EXEC and the counter is not built.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_pc_write,
    output logic       o_pc_write_cond,
    output logic       o_iord,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_mem_to_reg,
    output logic       o_reg_dst,
    output logic       o_reg_write,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_pc_src,
    output logic       o_md_start,
    output logic       o_lo_write,
    output logic       o_illegal,
    output logic [3:0] o_state
);
    localparam logic [5:0] MD_LOAD = 6'(MD_CYCLES - 1);

    state_e state_q, state_d;
    logic   illegal;
    logic   fetch;
    logic   unused_ok;

`ifdef MULTDIV_EN
    logic       md_load, md_dec, md_zero;
    logic [5:0] md_count;

    md_counter u_md_counter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (md_load),
        .i_dec      (md_dec),
        .i_load_val (MD_LOAD),
        .o_count    (md_count),
        .o_zero     (md_zero)
    );

    assign unused_ok = i_zero;
`else
    assign unused_ok = ^{i_zero, MD_LOAD};
`endif

    always_comb begin
        state_d = state_q;
        illegal = 1'b0;
`ifdef MULTDIV_EN
        md_load = 1'b0;
        md_dec  = 1'b0;
`endif
        case (state_q)
            ST_FETCH:    state_d = i_mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE:
                case (i_opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_EXEC;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_ADDI:      state_d = ST_ADDIEXEC;
                    OP_J:         state_d = ST_JUMP;
                    default: begin
                        state_d = ST_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            ST_MEMADR:   state_d = i_opcode == OP_SW ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:    state_d = i_mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWR:    state_d = i_mem_ready ? ST_FETCH : ST_MEMWR;
            ST_ADDIEXEC: state_d = ST_ADDIWB;
`ifdef MULTDIV_EN
            ST_EXEC: begin
                state_d = i_funct == FN_MULT ? ST_MDWAIT : ST_ALUWB;
                md_load = i_funct == FN_MULT;
            end
            ST_MDWAIT: begin
                state_d = md_zero ? ST_FETCH : ST_MDWAIT;
                md_dec  = !md_zero;
            end
`else
            ST_EXEC: begin
                state_d = i_funct == FN_MULT ? ST_FETCH : ST_ALUWB;
                illegal = i_funct == FN_MULT;
            end
`endif
            default:     state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) state_q <= ST_FETCH;
        else       state_q <= state_d;

    // Reset parks the FSM in FETCH, so only the FETCH strobes need explicit masking
    // to keep every output low while i_rst is high.
    assign fetch           = state_q == ST_FETCH && !i_rst;
    assign o_mem_read      = fetch || state_q == ST_MEMRD;
    assign o_mem_write     = state_q == ST_MEMWR;
    assign o_iord          = state_q == ST_MEMRD || state_q == ST_MEMWR;
    assign o_ir_write      = fetch && i_mem_ready;
    assign o_pc_write      = (fetch && i_mem_ready) || state_q == ST_JUMP;
    assign o_pc_write_cond = state_q == ST_BRANCH;
    assign o_mem_to_reg    = state_q == ST_MEMWB;
    assign o_reg_dst       = state_q == ST_ALUWB;
    assign o_reg_write     = state_q == ST_MEMWB || state_q == ST_ALUWB || state_q == ST_ADDIWB;
    assign o_alu_src_a     = state_q == ST_MEMADR || state_q == ST_EXEC
                          || state_q == ST_BRANCH || state_q == ST_ADDIEXEC;
    assign o_alu_src_b     = fetch ? 2'b01
                           : state_q == ST_DECODE ? 2'b11
                           : state_q == ST_MEMADR || state_q == ST_ADDIEXEC ? 2'b10 : 2'b00;
    assign o_alu_op        = state_q == ST_EXEC ? ALU_FUNCT : state_q == ST_BRANCH ? ALU_SUB : ALU_ADD;
    assign o_pc_src        = state_q == ST_BRANCH ? PC_BR : state_q == ST_JUMP ? PC_JMP : PC_ALU;
    assign o_illegal       = illegal;
    assign o_state         = state_q;
`ifdef MULTDIV_EN
    // The counter sits at its load value only during the first MDWAIT cycle.
    assign o_md_start      = state_q == ST_MDWAIT && md_count == MD_LOAD;
    assign o_lo_write      = state_q == ST_MDWAIT && md_zero;
`else
    assign o_md_start      = 1'b0;
    assign o_lo_write      = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for multicycle_control (MD_CYCLES = 4)
// Stimulus pushes the expected control word for each cycle; a negedge monitor pops and compares.
module tb_multicycle_control;
    typedef struct packed {
        logic       pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, psrc;
        logic       mds, low, ill;
        logic [3:0] st;
    } ctl_t;

    logic       i_clk = 1'b0, i_rst = 1'b1, i_zero = 1'b0, i_mem_ready = 1'b0;
    logic [5:0] i_opcode = '0, i_funct = '0;
    logic       o_pc_write, o_pc_write_cond, o_iord, o_mem_read, o_mem_write, o_ir_write;
    logic       o_mem_to_reg, o_reg_dst, o_reg_write, o_alu_src_a, o_md_start, o_lo_write, o_illegal;
    logic [1:0] o_alu_src_b, o_alu_op, o_pc_src;
    logic [3:0] o_state;
    ctl_t       act;
    ctl_t       q[$];
    int         n_vec = 0, n_bad = 0;

    multicycle_control #(.MD_CYCLES(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_funct(i_funct),
        .i_zero(i_zero), .i_mem_ready(i_mem_ready),
        .o_pc_write(o_pc_write), .o_pc_write_cond(o_pc_write_cond), .o_iord(o_iord),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_ir_write(o_ir_write),
        .o_mem_to_reg(o_mem_to_reg), .o_reg_dst(o_reg_dst), .o_reg_write(o_reg_write),
        .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b), .o_alu_op(o_alu_op),
        .o_pc_src(o_pc_src), .o_md_start(o_md_start), .o_lo_write(o_lo_write),
        .o_illegal(o_illegal), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    assign act = {o_pc_write, o_pc_write_cond, o_iord, o_mem_read, o_mem_write, o_ir_write,
                  o_mem_to_reg, o_reg_dst, o_reg_write, o_alu_src_a, o_alu_src_b, o_alu_op,
                  o_pc_src, o_md_start, o_lo_write, o_illegal, o_state};

    function automatic ctl_t exp_for(input int st, input bit rdy, input bit ill, input bit mds, input bit low);
        ctl_t e = '0;
        e.st = 4'(st);
        e.ill = ill;
        e.mds = mds;
        e.low = low;
        case (st)
            0:  begin e.mr = 1; e.asb = 2'b01; e.irw = rdy; e.pcw = rdy; end
            1:  e.asb = 2'b11;
            2:  begin e.asa = 1; e.asb = 2'b10; end
            3:  begin e.mr = 1; e.iord = 1; end
            4:  begin e.rw = 1; e.m2r = 1; end
            5:  begin e.mw = 1; e.iord = 1; end
            6:  begin e.asa = 1; e.aop = 2'b10; end
            7:  begin e.rw = 1; e.rdst = 1; end
            8:  begin e.asa = 1; e.aop = 2'b01; e.psrc = 2'b01; e.pcwc = 1; end
            9:  begin e.asa = 1; e.asb = 2'b10; end
            10: e.rw = 1;
            11: begin e.psrc = 2'b10; e.pcw = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic cyc(input int st, input bit rdy = 1'b0, input bit ill = 1'b0,
                       input bit mds = 1'b0, input bit low = 1'b0);
        i_mem_ready = rdy;
        q.push_back(exp_for(st, rdy, ill, mds, low));
        @(posedge i_clk);
        #1;
    endtask

    // Asserts reset between edges; the monitor sees the forced-zero outputs before any clock edge.
    task automatic rst_cyc();
        i_rst = 1'b1;
        i_mem_ready = 1'b1;
        q.push_back('0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic instr(input logic [5:0] opc, input logic [5:0] fn);
        i_opcode = opc;
        i_funct = fn;
    endtask

    always @(negedge i_clk)
        if (q.size() != 0) begin
            ctl_t e;
            e = q.pop_front();
            n_vec++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL vec%0d state%0d: got %h want %h", n_vec, e.st, act, e);
            end
        end

    initial begin
        @(posedge i_clk);
        #1;
        rst_cyc();
        cyc(0, 0);
        instr(6'b100011, 6'd0);
        cyc(0, 1); cyc(1, 1); cyc(2, 1); cyc(3, 1); cyc(4, 1);
        instr(6'b101011, 6'd0);
        cyc(0, 1); cyc(1, 0); cyc(2, 0); cyc(5, 0); cyc(5, 0); cyc(5, 0); cyc(5, 1);
        instr(6'b000100, 6'd0);
        i_zero = 1'b1;
        cyc(0, 1); cyc(1, 0); cyc(8, 1);
        instr(6'b000010, 6'd0);
        cyc(0, 1); cyc(1, 1); cyc(11, 0);
        instr(6'b000000, 6'b100000);
        cyc(0, 1); cyc(1, 0); cyc(6, 1); cyc(7, 0);
        instr(6'b001000, 6'd0);
        cyc(0, 1); cyc(1, 0); cyc(9, 0); cyc(10, 0);
        instr(6'b111111, 6'd0);
        cyc(0, 1); cyc(1, 0, 1); cyc(0, 0);
        instr(6'b000000, 6'b011000);
`ifdef MULTDIV_EN
        cyc(0, 1); cyc(1, 0); cyc(6, 0); cyc(12, 1, 0, 1); cyc(12); cyc(12); cyc(12, 0, 0, 0, 1);
        cyc(0, 0);
        cyc(0, 1); cyc(1, 0); cyc(6, 0); cyc(12, 0, 0, 1); cyc(12);
        rst_cyc();
        cyc(0, 0);
        cyc(0, 1); cyc(1, 0); cyc(6, 0); cyc(12, 0, 0, 1); cyc(12); cyc(12); cyc(12, 0, 0, 0, 1);
`else
        cyc(0, 1); cyc(1, 0); cyc(6, 0, 1);
`endif
        cyc(0, 0);
        instr(6'b100011, 6'd0);
        cyc(0, 1); cyc(1, 0); cyc(2, 0); cyc(3, 0); cyc(3, 0);
        rst_cyc();
        cyc(0, 1); cyc(1, 1); cyc(2, 1); cyc(3, 1); cyc(4, 0); cyc(0, 0);
        @(negedge i_clk);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
